// File: rtl/dmem_responder.sv
// Word-addressed data memory target: one outstanding request, response valid LATENCY edges after accept.
// Response is held until resp_ready; req_ready is low whenever a request is in flight or reset is high.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_access;
  logic             w_err;
  logic [IDX_W-1:0] w_idx;

  // Upper address bits are range-checked, never folded into the index.
  assign w_err    = (r_addr[1:0] != 2'b00) ||
                    ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign w_idx    = r_addr[IDX_W+1:2];
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

  assign req_ready  = (r_state == S_IDLE) && !reset;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // Write port kept free of reset so the array maps onto RAM; reset gating drops in-flight stores.
  always_ff @(posedge clk) begin
    if (w_access && !reset && r_we && !w_err) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // WAIT always spans LATENCY edges, so resp_valid rises LATENCY edges after the accept edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_addr       <= 32'd0;
      r_we         <= 1'b0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_addr  <= req_addr;
            r_we    <= req_we;
            r_wdata <= req_wdata;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_access) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
            r_rdata      <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
